// File: rtl/pdm_feeder.sv
// pdm_feeder
// Sample-rate stage in front of the PDM modulator. Buffers signed 8-bit
// samples from the producer in a small FIFO, generates the modulator's
// oversampling tick and presents one held level per audio sample period.
// Also reports FIFO fill and underruns so the producer can be paced.
//
// Ports:
//   clk_in              system clock
//   rst_in              asynchronous active-low reset
//   enable_in           run tick/sample timing (counters cleared while low)
//   sample_in           signed sample from producer
//   sample_valid_in     sample_in is valid
//   sample_ready_out    FIFO can accept a sample (fill < DEPTH)
//   level_out           level to modulator, held between loads
//   tick_out            one-cycle modulator tick strobe
//   fill_out            FIFO occupancy, 0..DEPTH
//   underrun_out        one-cycle pulse after a load found the FIFO empty
//   underrun_count_out  underrun count, saturating at 255
module pdm_feeder #(
  parameter int TICK_DIV   = 8,
  parameter int SAMPLE_DIV = 256,
  parameter int DEPTH      = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     enable_in,
  input  logic [7:0]               sample_in,
  input  logic                     sample_valid_in,
  output logic                     sample_ready_out,
  output logic [7:0]               level_out,
  output logic                     tick_out,
  output logic [$clog2(DEPTH):0]   fill_out,
  output logic                     underrun_out,
  output logic [7:0]               underrun_count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_samp_cnt;
  logic          r_tick;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [FW-1:0] r_fill;
  logic [7:0]    r_level;
  logic          r_underrun;
  logic [7:0]    r_ucount;

  logic w_tick;
  logic w_load;
  logic w_ready;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // r_tick is registered one cycle ahead so tick_out is a clean flop output;
  // it is high exactly in the cycle where the tick counter sits at its last value.
  assign w_tick  = r_tick & enable_in;
  assign w_load  = w_tick & (r_samp_cnt == SAMP_LAST);
  assign w_ready = (r_fill != FILL_FULL);
  assign w_empty = (r_fill == '0);
  assign w_push  = sample_valid_in & w_ready;
  assign w_pop   = w_load & ~w_empty;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (!enable_in) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
      r_tick     <= (r_tick_cnt == TICK_PRE);
      if (w_tick) begin
        r_samp_cnt <= (r_samp_cnt == SAMP_LAST) ? '0 : r_samp_cnt + 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_level    <= '0;
      r_underrun <= 1'b0;
      r_ucount   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_level  <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      // A push landing on an empty load cycle is still an underrun; the new
      // sample waits for the next load.
      r_underrun <= w_load & w_empty;
      if (w_load && w_empty && (r_ucount != 8'hFF)) begin
        r_ucount <= r_ucount + 1'b1;
      end
    end
  end

  assign sample_ready_out   = w_ready;
  assign level_out          = r_level;
  assign tick_out           = r_tick;
  assign fill_out           = r_fill;
  assign underrun_out       = r_underrun;
  assign underrun_count_out = r_ucount;

endmodule

// File: tb/tb_pdm_feeder.sv
module tb_pdm_feeder;

  localparam int TD    = 4;
  localparam int SD    = 2;
  localparam int DEPTH = 4;
  localparam int LP    = TD * SD;

  logic                   clk_in;
  logic                   rst_in;
  logic                   enable_in;
  logic [7:0]             sample_in;
  logic                   sample_valid_in;
  logic                   sample_ready_out;
  logic [7:0]             level_out;
  logic                   tick_out;
  logic [$clog2(DEPTH):0] fill_out;
  logic                   underrun_out;
  logic [7:0]             underrun_count_out;

  pdm_feeder #(.TICK_DIV(TD), .SAMPLE_DIV(SD), .DEPTH(DEPTH)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .enable_in          (enable_in),
    .sample_in          (sample_in),
    .sample_valid_in    (sample_valid_in),
    .sample_ready_out   (sample_ready_out),
    .level_out          (level_out),
    .tick_out           (tick_out),
    .fill_out           (fill_out),
    .underrun_out       (underrun_out),
    .underrun_count_out (underrun_count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: sample queue plus count of consecutive enabled cycles.
  logic [7:0] q[$];
  int         p;
  logic [7:0] m_level;
  int         m_ucnt;
  bit         m_und;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    p       = 0;
    m_level = 8'h00;
    m_ucnt  = 0;
    m_und   = 0;
  endtask

  // One clock cycle: drive inputs, check this cycle's tick/ready, then
  // advance the model across the edge and check the registered outputs.
  task automatic cyc(input bit en, input bit v, input logic [7:0] d);
    bit exp_tick, load, rdy;
    enable_in       = en;
    sample_valid_in = v;
    sample_in       = d;
    exp_tick = en && ((p % TD) == TD - 1);
    load     = en && ((p % LP) == LP - 1);
    rdy      = (q.size() < DEPTH);
    chk("tick", tick_out, exp_tick);
    chk("ready", sample_ready_out, rdy);
    @(posedge clk_in);
    #1;
    m_und = 0;
    if (load) begin
      if (q.size() > 0) m_level = q.pop_front();
      else begin
        m_und = 1;
        if (m_ucnt < 255) m_ucnt++;
      end
    end
    if (v && rdy) q.push_back(d);
    p = en ? p + 1 : 0;
    chk("level", level_out, m_level);
    chk("fill", fill_out, q.size());
    chk("underrun", underrun_out, m_und);
    chk("ucount", underrun_count_out, m_ucnt);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_level"}, level_out, 8'h00);
    chk({tag, "_fill"}, fill_out, 0);
    chk({tag, "_tick"}, tick_out, 1'b0);
    chk({tag, "_und"}, underrun_out, 1'b0);
    chk({tag, "_ucnt"}, underrun_count_out, 8'h00);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    enable_in       = 1'b0;
    sample_valid_in = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    check_reset_vals("rst_async");
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    model_reset();
    chk("rst_ready", sample_ready_out, 1'b1);
  endtask

  logic [7:0] d;
  bit         en_cur;
  bit         en_nxt;
  bit         acc;
  int         vprob;

  initial begin
    rst_in          = 1'b0;
    enable_in       = 1'b0;
    sample_valid_in = 1'b0;
    sample_in       = 8'h00;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_vals("por");
    chk("por_ready", sample_ready_out, 1'b1);
    rst_in = 1'b1;

    // Ordered playback
    cyc(0, 1, 8'h7F);
    cyc(0, 1, 8'h80);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'hC3);
    chk("play_full_ready", sample_ready_out, 1'b0);
    repeat (40) cyc(1, 0, 8'h00);
    chk("play_level_last", level_out, 8'hC3);
    chk("play_fill_zero", fill_out, 0);

    // Underrun with last level 0x25, then saturation
    cyc(0, 1, 8'h25);
    repeat (8) cyc(1, 0, 8'h00);
    chk("und_level_loaded", level_out, 8'h25);
    repeat (8) cyc(1, 0, 8'h00);
    chk("und_level_held", level_out, 8'h25);
    repeat (300 * LP) cyc(1, 0, 8'h00);
    chk("und_saturated", underrun_count_out, 8'd255);

    // Backpressure with a continuously valid producer
    d = 8'h10;
    repeat (6) begin
      acc = (q.size() < DEPTH);
      cyc(0, 1, d);
      if (acc) d++;
    end
    chk("bp_ready_low", sample_ready_out, 1'b0);
    repeat (48) begin
      acc = (q.size() < DEPTH);
      cyc(1, 1, d);
      if (acc) d++;
    end

    // Enable gating mid-period and restart
    repeat (5) cyc(1, 0, 8'h00);
    repeat (6) cyc(0, 0, 8'h00);
    repeat (20) cyc(1, 0, 8'h00);

    // Randomized traffic with occasional enable drops
    en_cur = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      vprob = (i < 750) ? 20 : 70;
      if (en_cur) en_nxt = ($urandom_range(0, 49) != 0);
      else        en_nxt = ($urandom_range(0, 9) != 0);
      if (en_cur && !en_nxt && ((p % TD) == TD - 1)) en_nxt = 1'b1;
      cyc(en_nxt, ($urandom_range(0, 99) < vprob), 8'($urandom));
      en_cur = en_nxt;
    end

    // Mid-stream reset with samples buffered
    do_reset();
    cyc(0, 1, 8'h11);
    cyc(0, 1, 8'h22);
    cyc(0, 1, 8'h33);
    chk("pre_rst_fill", fill_out, 3);
    do_reset();
    chk("post_rst_fill", fill_out, 0);
    repeat (LP) cyc(1, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
